beeper_arbiter: RTL and testbench
=================================

Name: beeper_arbiter

Overview:
- Shares the single PWM beeper datapath between three tone sources: alert chime, manual keyboard and auto music player.
- Owns the 16-bit PWM cycle word fed to the PWM instance. Duty is always cycle>>1 and is derived outside this block.
- Enforces a fixed priority, a minimum note hold time and a silent gap on every source switch, so notes are never truncated or glued together.
- Sits between the tone/Music_Player outputs and the PWM instance, replacing the old mode-select mux.

Parameters:
- WIDTH, 16, width of every tone cycle word.
- HOLD_CYCLES, 120000, minimum clocks a grant is held before release or preemption (10 ms at 12 MHz); must be at least 1.
- GAP_CYCLES, 12000, clocks of forced silence between two different grants (1 ms); must be at least 1.

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  reset, synchronous, active-low.
- req_alert  in  1  alert source requests beeper; highest priority.
- tone_alert  in  WIDTH  alert PWM cycle.
- req_manual  in  1  manual keyboard requests beeper (any key down); middle priority.
- tone_manual  in  WIDTH  manual PWM cycle (tone module output).
- req_auto  in  1  music player requests beeper; lowest priority.
- tone_auto  in  WIDTH  auto PWM cycle.
- grant  out  3  one-hot grant {alert, manual, auto}; 000 when nobody is granted.
- tone_cycle  out  WIDTH  cycle word to PWM; 0 means silence.
- busy  out  1  high in PLAY or GAP.

Behaviour:
- Reset (rst_n_in low at a clock edge): state=IDLE, grant=000, tone_cycle=0, busy=0, hold and gap counters 0. Reset mid-note silences the beeper on the next edge.
- All outputs are registered. Winner = highest-priority asserted req (alert > manual > auto).
- IDLE: tone_cycle=0. If any req is high, go to PLAY on the next edge with grant=winner, tone_cycle=winner's tone and hold counter cleared. Latency from req to tone is 1 clock.
- PLAY:
  - Hold counter increments, saturating at HOLD_CYCLES. hold_done = (counter == HOLD_CYCLES).
  - While the granted req is high, tone_cycle tracks the granted tone with 1-clock latency. A manual key change does not re-grant and does not reset hold.
  - Granted req drops before hold_done: the last tone is latched and held until hold_done.
  - Granted req low and hold_done: if any other req is high, go to GAP; otherwise go to IDLE (grant=000, tone_cycle=0).
  - A higher-priority req with hold_done: go to GAP (preemption). Lower-priority reqs never preempt.
  - Granted req high, hold_done, and no higher request: stay in PLAY indefinitely.
  - A granted tone of 0 is legal and plays as silence while keeping the grant.
- GAP:
  - grant=000, tone_cycle=0, counter runs for exactly GAP_CYCLES clocks.
  - At the end, the winner is re-evaluated at that edge: go to PLAY with the new winner, or to IDLE if no req is high. Requests that come and go during GAP are ignored.
- Simultaneous events: a granted-req drop in the same cycle as a higher-priority req resolves as a switch through GAP. A same-source re-request during GAP is granted normally after the gap.
- busy = (state != IDLE).

Optional Feature:
- BEEPER_ARB_ALERT_PREEMPT_EN defined: a rising req_alert in PLAY with a non-alert grant goes to GAP immediately, ignoring hold_done.
- Undefined: alert waits for hold_done like any other preemption.

Decomposition:
- Package beeper_pkg holds:
  - the state encoding (IDLE, PLAY, GAP);
  - grant bit index constants GNT_ALERT=2, GNT_MANUAL=1, GNT_AUTO=0;
  - a SILENCE constant equal to 0.
- One natural sub-module, beeper_prio_enc: combinational fixed-priority encoder producing the one-hot winner plus an any_req flag. It is reused for the initial grant and for preemption checks.

Test Plan (HOLD_CYCLES=8, GAP_CYCLES=4):
- Reset, then req_manual=1 with tone_manual=0x5D5F. Required: grant=010 and tone_cycle=0x5D5F one clock later; busy=1.
- Manual grant, req_manual pulsed for 2 clocks only. Required: 0x5D5F held for 8 clocks, then IDLE with tone 0.
- Auto playing tone 0x3A98, req_manual raised at clock 3 of PLAY. Required: switch at clock 8, 4 clocks of grant=000/tone 0, then grant=010.
- Manual playing, req_auto raised. Required: no preemption; auto is granted only after manual releases, via a 4-clock gap.
- Auto playing, req_alert raised at clock 2. Without the macro: gap starts at clock 8. With BEEPER_ARB_ALERT_PREEMPT_EN: gap starts the next clock; grant becomes 100 after 4 silent clocks.
- rst_n_in low for 1 clock during PLAY. Required: grant=000 and tone_cycle=0 at that edge; a fresh request afterwards restarts hold from 0.

Source files
------------

// File: rtl/beeper_pkg.sv
// Shared encodings for the beeper arbiter: FSM states, grant bit positions, silence word.
package beeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int unsigned GNT_ALERT  = 2;
  localparam int unsigned GNT_MANUAL = 1;
  localparam int unsigned GNT_AUTO   = 0;

  localparam int unsigned SILENCE = 0;

endpackage

// File: rtl/beeper_prio_enc.sv
// Fixed-priority encoder over {alert, manual, auto}: one-hot winner plus any-request flag.
module beeper_prio_enc
  import beeper_pkg::*;
(
  input  logic [2:0] req_i,
  output logic [2:0] win_o,
  output logic       any_o
);

  always_comb begin
    win_o = '0;
    if (req_i[GNT_ALERT]) begin
      win_o[GNT_ALERT] = 1'b1;
    end else if (req_i[GNT_MANUAL]) begin
      win_o[GNT_MANUAL] = 1'b1;
    end else if (req_i[GNT_AUTO]) begin
      win_o[GNT_AUTO] = 1'b1;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/beeper_arbiter.sv
// Beeper source arbiter: priority grant with minimum note hold and silent gap on switch.
// Define BEEPER_ARB_ALERT_PREEMPT_EN to let a rising alert cut a note short.
module beeper_arbiter
  import beeper_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned HOLD_CYCLES = 120000,
  parameter int unsigned GAP_CYCLES  = 12000
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             req_alert,
  input  logic [WIDTH-1:0] tone_alert,
  input  logic             req_manual,
  input  logic [WIDTH-1:0] tone_manual,
  input  logic             req_auto,
  input  logic [WIDTH-1:0] tone_auto,
  output logic [2:0]       grant,
  output logic [WIDTH-1:0] tone_cycle,
  output logic             busy
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  state_e           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [WIDTH-1:0] tone_q, tone_d;
  logic             busy_q, busy_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic [2:0]       req_vec;
  logic [2:0]       win;
  logic             any_req;
  logic [HW-1:0]    hold_inc;
  logic             hold_done;
  logic             gnt_req;
  logic             higher_req;
  logic             other_req;
  logic             alert_preempt;
  logic [WIDTH-1:0] win_tone;
  logic [WIDTH-1:0] gnt_tone;

  assign req_vec = {req_alert, req_manual, req_auto};

  beeper_prio_enc u_prio (
    .req_i (req_vec),
    .win_o (win),
    .any_o (any_req)
  );

  function automatic logic [WIDTH-1:0] pick_tone(input logic [2:0] oh,
                                                 input logic [WIDTH-1:0] t_alert,
                                                 input logic [WIDTH-1:0] t_manual,
                                                 input logic [WIDTH-1:0] t_auto);
    pick_tone = WIDTH'(SILENCE);
    if (oh[GNT_ALERT])  pick_tone = t_alert;
    if (oh[GNT_MANUAL]) pick_tone = t_manual;
    if (oh[GNT_AUTO])   pick_tone = t_auto;
  endfunction

  assign win_tone = pick_tone(win, tone_alert, tone_manual, tone_auto);
  assign gnt_tone = pick_tone(grant_q, tone_alert, tone_manual, tone_auto);

  // One-hot with higher bit = higher priority, so a numerically larger winner outranks the grant.
  assign higher_req = (win > grant_q);
  assign gnt_req    = |(req_vec & grant_q);
  assign other_req  = |(req_vec & ~grant_q);
  assign hold_inc   = (hold_q == HW'(HOLD_CYCLES)) ? hold_q : hold_q + HW'(1);
  assign hold_done  = (hold_inc == HW'(HOLD_CYCLES));

`ifdef BEEPER_ARB_ALERT_PREEMPT_EN
  logic alert_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      alert_q <= 1'b0;
    end else begin
      alert_q <= req_alert;
    end
  end

  assign alert_preempt = req_alert && !alert_q && !grant_q[GNT_ALERT];
`else
  assign alert_preempt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    tone_d  = tone_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_PLAY;
          grant_d = win;
          tone_d  = win_tone;
          hold_d  = '0;
        end
      end
      ST_PLAY: begin
        hold_d = hold_inc;
        // Dropped request keeps the last tone latched until the hold expires.
        if (gnt_req) tone_d = gnt_tone;
        if (alert_preempt || (hold_done && (higher_req || (!gnt_req && other_req)))) begin
          state_d = ST_GAP;
          grant_d = '0;
          tone_d  = WIDTH'(SILENCE);
          gap_d   = '0;
        end else if (hold_done && !gnt_req) begin
          state_d = ST_IDLE;
          grant_d = '0;
          tone_d  = WIDTH'(SILENCE);
        end
      end
      ST_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          if (any_req) begin
            state_d = ST_PLAY;
            grant_d = win;
            tone_d  = win_tone;
            hold_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        tone_d  = WIDTH'(SILENCE);
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      tone_q  <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  assign grant      = grant_q;
  assign tone_cycle = tone_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_beeper_arbiter.sv
// Scoreboard bench for beeper_arbiter: directed scenarios plus randomized request traffic.
module tb_beeper_arbiter;

  localparam int unsigned W    = 16;
  localparam int          HOLD = 8;
  localparam int          GAP  = 4;
`ifdef BEEPER_ARB_ALERT_PREEMPT_EN
  localparam int ALERT_GS = 2;
`else
  localparam int ALERT_GS = 8;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ra = 1'b0, rm = 1'b0, rau = 1'b0;
  logic [W-1:0] ta = '0, tm = '0, tu = '0;
  logic [2:0]   grant;
  logic [W-1:0] tone;
  logic         busy;

  always #5 clk = ~clk;

  beeper_arbiter #(
    .WIDTH       (W),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .req_alert   (ra),
    .tone_alert  (ta),
    .req_manual  (rm),
    .tone_manual (tm),
    .req_auto    (rau),
    .tone_auto   (tu),
    .grant       (grant),
    .tone_cycle  (tone),
    .busy        (busy)
  );

  typedef struct {
    logic [2:0]   g;
    logic [W-1:0] t;
    logic         b;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference: owner index (-1 none), clocks played, silent clocks remaining.
  int           m_owner = -1;
  int           m_age = 0;
  int           m_gap = 0;
  logic [W-1:0] m_tone = '0;
  logic         m_prev_alert = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic [2:0]   r;
    logic [W-1:0] tn[3];
    int           best;
    bit           go_gap, go_idle, done;
    exp_t         e;
    r = {ra, rm, rau};
    tn[0] = tu; tn[1] = tm; tn[2] = ta;
    best = -1;
    for (int i = 0; i < 3; i++) if (r[i]) best = i;
    go_gap = 0; go_idle = 0;
    if (!rst_n) begin
      m_owner = -1; m_age = 0; m_gap = 0; m_tone = '0;
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0 && best >= 0) begin
        m_owner = best; m_age = 0; m_tone = tn[best];
      end
    end else if (m_owner < 0) begin
      if (best >= 0) begin
        m_owner = best; m_age = 0; m_tone = tn[best];
      end
    end else begin
      m_age++;
      done = (m_age >= HOLD);
      if (r[m_owner]) m_tone = tn[m_owner];
      if (done && best > m_owner) go_gap = 1;
      if (done && !r[m_owner]) begin
        if (best >= 0) go_gap = 1;
        else go_idle = 1;
      end
`ifdef BEEPER_ARB_ALERT_PREEMPT_EN
      if (ra && !m_prev_alert && m_owner != 2) go_gap = 1;
`endif
      if (go_gap) begin
        m_owner = -1; m_tone = '0; m_gap = GAP;
      end else if (go_idle) begin
        m_owner = -1; m_tone = '0;
      end
    end
    m_prev_alert = rst_n ? ra : 1'b0;
    e.g = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    e.t = m_tone;
    e.b = (m_owner >= 0) || (m_gap > 0);
    sb.push_back(e);
  endtask

  // Predict the coming edge, then step just past it.
  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int idx, input logic v);
    case (idx)
      0: rau = v;
      1: rm  = v;
      default: ra = v;
    endcase
  endtask

  task automatic switch_case(input string nm, input int first, input int second,
                             input int raise_at, input int release_at, input int gs);
    logic [2:0] exp_g;
    set_req(first, 1'b1);
    tick();
    check({nm, "_grant0"}, 32'(grant), 32'(1 << first));
    for (int k = 1; k <= gs + GAP + 2; k++) begin
      if (k == raise_at) set_req(second, 1'b1);
      if (k == release_at) set_req(first, 1'b0);
      tick();
      exp_g = (k < gs) ? 3'(1 << first) : (k < gs + GAP) ? 3'b000 : 3'(1 << second);
      check({nm, "_grant"}, 32'(grant), 32'(exp_g));
    end
    ra = 1'b0; rm = 1'b0; rau = 1'b0;
    repeat (14) tick();
    check({nm, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_grant", 32'(grant), 32'(e.g));
        check("sb_tone", 32'(tone), 32'(e.t));
        check("sb_busy", 32'(busy), 32'(e.b));
      end
    end
  end

  initial begin : driver
    tu = 16'h3A98; tm = 16'h5D5F; ta = 16'h1F40;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tone", 32'(tone), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    rst_n = 1'b1;
    rm = 1'b1;
    tick();
    check("first_grant", 32'(grant), 32'b010);
    check("first_tone", 32'(tone), 32'h5D5F);
    check("first_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) rm = 1'b0;
      check("pulse_hold_tone", 32'(tone), 32'h5D5F);
    end
    tick();
    check("pulse_end_grant", 32'(grant), 32'd0);
    check("pulse_end_tone", 32'(tone), 32'd0);

    rm = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_tone", 32'(tone), 32'd0);
    rst_n = 1'b1;
    tick();
    check("postrst_grant", 32'(grant), 32'b010);
    rm = 1'b0;
    repeat (7) tick();
    check("postrst_hold", 32'(grant), 32'b010);
    tick();
    check("postrst_release", 32'(grant), 32'd0);

    switch_case("auto_to_manual", 0, 1, 3, 1000, HOLD);
    switch_case("auto_to_alert", 0, 2, 2, 1000, ALERT_GS);
    switch_case("manual_no_preempt", 1, 0, 2, 10, 10);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 11) == 0) ra = ~ra;
      if ($urandom_range(0, 4) == 0) rm = ~rm;
      if ($urandom_range(0, 5) == 0) rau = ~rau;
      if ($urandom_range(0, 3) == 0) tm = ($urandom_range(0, 5) == 0) ? '0 : 16'($urandom);
      if ($urandom_range(0, 7) == 0) tu = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ta = ($urandom_range(0, 5) == 0) ? '0 : 16'($urandom);
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end

    @(posedge clk);
    #2;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
